// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 divider (signed/unsigned) producing {remainder, quotient}.
// One quotient bit per cycle; the result is held in END until the requester drops start_i.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH:0]     work_q, work_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic                 quo_neg_q, quo_neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_abs, b_abs;
    logic [2*WIDTH:0]     shifted, step;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH+1:0]     trial;
    logic [WIDTH-1:0]     quo_raw, rem_raw, quo_fix, rem_fix;

    // Operands are divided as magnitudes; signs are reapplied on the final iteration.
    always_comb begin
        a_neg = signed_div_i & opdata1_i[WIDTH-1];
        b_neg = signed_div_i & opdata2_i[WIDTH-1];
        a_abs = a_neg ? (~opdata1_i + 1'b1) : opdata1_i;
        b_abs = b_neg ? (~opdata2_i + 1'b1) : opdata2_i;
    end

    // Working register layout: {partial remainder (WIDTH+1), dividend/quotient (WIDTH)}.
    always_comb begin
        shifted = {work_q[2*WIDTH-1:0], 1'b0};
        rem_sh  = shifted[2*WIDTH:WIDTH];
        trial   = {1'b0, rem_sh} - {2'b00, divisor_q};
        if (trial[WIDTH+1]) begin
            step = {rem_sh, shifted[WIDTH-1:1], 1'b0};
        end else begin
            step = {trial[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
        end
        quo_raw = step[WIDTH-1:0];
        rem_raw = step[2*WIDTH-1:WIDTH];
        quo_fix = quo_neg_q ? (~quo_raw + 1'b1) : quo_raw;
        rem_fix = rem_neg_q ? (~rem_raw + 1'b1) : rem_raw;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;
        case (state_q)
            FREE: begin
                if (start_i && !annul_i) begin
                    divisor_d = b_abs;
                    quo_neg_d = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    cnt_d     = '0;
                    work_d    = {{(WIDTH+1){1'b0}}, a_abs};
                    state_d   = (opdata2_i == '0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                if (annul_i) begin
                    state_d = FREE;
                end else begin
                    state_d  = END;
                    result_d = '0;
                end
            end
            ON: begin
                if (annul_i) begin
                    state_d = FREE;
                    cnt_d   = '0;
                    work_d  = '0;
                end else begin
                    work_d = step;
                    if (cnt_q == LAST) begin
                        state_d  = END;
                        cnt_d    = '0;
                        result_d = {rem_fix, quo_fix};
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            END: begin
                if (!start_i) begin
                    state_d  = FREE;
                    result_d = '0;
                end
            end
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FREE;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = (state_q == END);
    assign busy_o   = (state_q == ON) || (state_q == BYZERO);

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: 32-bit and 8-bit instances, hand-computed results.
`timescale 1ns/1ps
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start32 = 1'b0, annul32 = 1'b0, sdiv32 = 1'b0;
    logic [31:0] op1_32 = '0, op2_32 = '0;
    logic [63:0] res32;
    logic        ready32, busy32;
    logic        start8 = 1'b0, annul8 = 1'b0, sdiv8 = 1'b0;
    logic [7:0]  op1_8 = '0, op2_8 = '0;
    logic [15:0] res8;
    logic        ready8, busy8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start_i(start32), .annul_i(annul32),
        .signed_div_i(sdiv32), .opdata1_i(op1_32), .opdata2_i(op2_32),
        .result_o(res32), .ready_o(ready32), .busy_o(busy32)
    );

    div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .annul_i(annul8),
        .signed_div_i(sdiv8), .opdata1_i(op1_8), .opdata2_i(op2_8),
        .result_o(res8), .ready_o(ready8), .busy_o(busy8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full 32-bit transaction: accept, iterate (operands scrambled mid-flight),
    // hold in END with annul asserted, then release.
    task automatic div32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input int exp_cyc, input logic [63:0] exp_res);
        int cyc;
        op1_32 = a; op2_32 = b; sdiv32 = sgn; start32 = 1'b1;
        tick();
        chk({tag, " busy"}, 64'(busy32), 64'd1);
        cyc = 0;
        while (!ready32 && cyc < 100) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                op1_32 = ~a;
                op2_32 = b + 32'd5;
            end
        end
        chk({tag, " cycles"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, " result"}, res32, exp_res);
        chk({tag, " idle_at_ready"}, 64'(busy32), 64'd0);
        annul32 = 1'b1;
        tick();
        tick();
        chk({tag, " hold"}, {res32[62:0], ready32}, {exp_res[62:0], 1'b1});
        annul32 = 1'b0;
        start32 = 1'b0;
        tick();
        chk({tag, " release"}, {res32[62:0], ready32}, 64'd0);
        $display("div32 %s a=%h b=%h s=%0d cycles=%0d result=%h", tag, a, b, sgn, cyc, res32);
    endtask

    task automatic div8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic sgn, input logic [15:0] exp_res);
        int cyc;
        op1_8 = a; op2_8 = b; sdiv8 = sgn; start8 = 1'b1;
        tick();
        cyc = 0;
        while (!ready8 && cyc < 50) begin
            tick();
            cyc++;
            if (cyc == 3) begin
                op1_8 = 8'h10;
                op2_8 = 8'h03;
            end
        end
        chk({tag, " cycles"}, 64'(cyc), 64'd8);
        chk({tag, " result"}, 64'(res8), 64'(exp_res));
        start8 = 1'b0;
        tick();
        chk({tag, " release"}, 64'({ready8, res8}), 64'd0);
        $display("div8 %s a=%h b=%h s=%0d cycles=%0d", tag, a, b, sgn, cyc);
    endtask

    initial begin
        int seen_ready;
        #2;
        chk("reset outputs", {res32[60:0], ready32, busy32, 1'b0}, 64'd0);
        tick();
        tick();
        rst = 1'b1;

        div32("u100/7",  32'd100,       32'd7,         1'b0, 32, 64'h00000002_0000000E);
        div32("s-7/2",   32'hFFFFFFF9,  32'd2,         1'b1, 32, 64'hFFFFFFFF_FFFFFFFD);
        div32("s_ovf",   32'h80000000,  32'hFFFFFFFF,  1'b1, 32, 64'h00000000_80000000);
        div32("u_big",   32'h80000000,  32'hFFFFFFFF,  1'b0, 32, 64'h80000000_00000000);
        div32("s7/-2",   32'd7,         32'hFFFFFFFE,  1'b1, 32, 64'h00000001_FFFFFFFD);
        div32("s-100/-7",32'hFFFFFF9C,  32'hFFFFFFF9,  1'b1, 32, 64'hFFFFFFFE_0000000E);
        div32("u5/9",    32'd5,         32'd9,         1'b0, 32, 64'h00000005_00000000);
        div32("uMax/1",  32'hFFFFFFFF,  32'd1,         1'b0, 32, 64'h00000000_FFFFFFFF);
        div32("byzero",  32'h12345678,  32'd0,         1'b0, 1,  64'd0);

        // Annul at iteration 10, then a fresh 9/3.
        op1_32 = 32'd100; op2_32 = 32'd7; sdiv32 = 1'b0; start32 = 1'b1;
        tick();
        repeat (10) tick();
        annul32 = 1'b1; start32 = 1'b0;
        tick();
        annul32 = 1'b0;
        chk("annul busy", 64'(busy32), 64'd0);
        seen_ready = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready32 || res32 != 64'd0) seen_ready = 1;
            tick();
        end
        chk("annul no_ready", 64'(seen_ready), 64'd0);
        $display("annul at iteration 10 done");
        div32("u9/3",    32'd9,         32'd3,         1'b0, 32, 64'h00000000_00000003);

        // Asynchronous reset at iteration 20, away from any clock edge.
        op1_32 = 32'd100; op2_32 = 32'd7; start32 = 1'b1;
        tick();
        repeat (20) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("async rst outputs", {res32[61:0], ready32, busy32}, 64'd0);
        $display("async reset mid-divide done");
        start32 = 1'b0;
        tick();
        rst = 1'b1;
        div32("post_rst", 32'd100,      32'd7,         1'b0, 32, 64'h00000002_0000000E);

        div8("u255/1", 8'hFF, 8'h01, 1'b0, 16'h00FF);
        div8("s-56/5", 8'hC8, 8'h05, 1'b1, 16'hFFF5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
